// File: rtl/uart_frame_parser_if.sv
// Byte-receiver input side and committed-frame output side of uart_frame_parser.
// The parser uses the slave modport; the driving and observing side uses master.
interface uart_frame_parser_if #(
  parameter int unsigned MAX_LEN = 8
);
  logic                   rx_ready;
  logic [7:0]             rx_data;
  logic                   rx_eop;
  logic                   frame_valid;
  logic [7:0]             frame_cmd;
  logic [3:0]             frame_len;
  logic [8*MAX_LEN-1:0]   frame_payload;
  logic                   frame_err;
  logic [1:0]             err_code;
  logic [7:0]             frame_count;
  logic                   busy;

  modport master (
    output rx_ready, rx_data, rx_eop,
    input  frame_valid, frame_cmd, frame_len, frame_payload,
           frame_err, err_code, frame_count, busy
  );

  modport slave (
    input  rx_ready, rx_data, rx_eop,
    output frame_valid, frame_cmd, frame_len, frame_payload,
           frame_err, err_code, frame_count, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SYNC/CMD/LEN/PAYLOAD/CHK byte frames with XOR checksum and gap abort.
// Optional watchdog abort enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN       = 8,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 50000
) (
  input logic               clk,
  input logic               rst_n,
  uart_frame_parser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_GAP = 2'd3;

  if (MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_TICKS < 2 || TIMEOUT_TICKS > 65536) begin : g_bad_cfg
    $error("uart_frame_parser: parameter out of range");
  end

  state_t                 state_q, state_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [3:0]             len_q, len_d;
  logic [3:0]             idx_q, idx_d;
  logic [7:0]             chk_q, chk_d;
  logic [8*MAX_LEN-1:0]   buf_q, buf_d;
  logic                   fv_q, fv_d;
  logic                   fe_q, fe_d;
  logic [1:0]             code_q, code_d;
  logic [7:0]             fcmd_q, fcmd_d;
  logic [3:0]             flen_q, flen_d;
  logic [8*MAX_LEN-1:0]   fpay_q, fpay_d;
  logic [7:0]             fcnt_q, fcnt_d;
  logic                   tmo;

  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_eop;

  assign rx_ready = bus.rx_ready;
  assign rx_data  = bus.rx_data;
  assign rx_eop   = bus.rx_eop;

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;

  // A byte arriving on the expiry cycle wins over the watchdog.
  assign tmo = (state_q != IDLE) && !rx_ready &&
               (timer_q == 16'(TIMEOUT_TICKS - 1));
  assign timer_d = (rx_ready || state_d == IDLE) ? '0 : timer_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    buf_d   = buf_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    code_d  = code_q;
    fcmd_d  = fcmd_q;
    flen_d  = flen_q;
    fpay_d  = fpay_q;
    fcnt_d  = fcnt_q;

    if (rx_ready) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = CMD;
            buf_d   = '0;
            idx_d   = '0;
            chk_d   = '0;
          end
        end
        CMD: begin
          cmd_d   = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = LEN;
        end
        LEN: begin
          if (rx_data > 8'(MAX_LEN)) begin
            fe_d    = 1'b1;
            code_d  = ERR_LEN;
            state_d = IDLE;
          end else begin
            len_d   = rx_data[3:0];
            idx_d   = '0;
            chk_d   = chk_q ^ rx_data;
            state_d = (rx_data == 8'd0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) buf_d[8*i +: 8] = rx_data;
          end
          chk_d = chk_q ^ rx_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) state_d = CHK;
        end
        CHK: begin
          if (rx_data == chk_q) begin
            fv_d   = 1'b1;
            fcmd_d = cmd_q;
            flen_d = len_q;
            fpay_d = buf_q;
            fcnt_d = fcnt_q + 8'd1;
          end else begin
            fe_d   = 1'b1;
            code_d = ERR_CHK;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && (rx_eop || tmo)) begin
      fe_d    = 1'b1;
      code_d  = ERR_GAP;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      buf_q   <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      code_q  <= '0;
      fcmd_q  <= '0;
      flen_q  <= '0;
      fpay_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      buf_q   <= buf_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      code_q  <= code_d;
      fcmd_q  <= fcmd_d;
      flen_q  <= flen_d;
      fpay_q  <= fpay_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.frame_valid   = fv_q;
  assign bus.frame_err     = fe_q;
  assign bus.err_code      = code_q;
  assign bus.frame_cmd     = fcmd_q;
  assign bus.frame_len     = flen_q;
  assign bus.frame_payload = fpay_q;
  assign bus.frame_count   = fcnt_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed table-driven bench for uart_frame_parser plus reset, abort and wrap sequences.
module tb_uart_frame_parser;

  localparam int unsigned TMO = 40;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  uart_frame_parser_if #(.MAX_LEN(8)) bus ();

  uart_frame_parser #(
    .MAX_LEN      (8),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [7:0]  data;
    logic        eop;
    logic        ev;
    logic        ee;
    logic [1:0]  ec;
    logic        eb;
    logic [7:0]  ecmd;
    logic [3:0]  elen;
    logic [7:0]  ecnt;
    logic [63:0] epay;
  } vec_t;

  vec_t        vq[$];
  logic [7:0]  hc;
  logic [3:0]  hl;
  logic [7:0]  hn;
  logic [63:0] hp;

  task automatic add(input logic rdy, input logic [7:0] d, input logic eop,
                     input logic ev, input logic ee, input logic [1:0] ec, input logic eb);
    vec_t v;
    v.rdy = rdy; v.data = d; v.eop = eop;
    v.ev = ev; v.ee = ee; v.ec = ec; v.eb = eb;
    v.ecmd = hc; v.elen = hl; v.ecnt = hn; v.epay = hp;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample just after the edge, then drop the pulses.
  task automatic step(input logic rdy, input logic [7:0] d, input logic eop);
    @(negedge clk);
    bus.rx_ready = rdy;
    bus.rx_data  = d;
    bus.rx_eop   = eop;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    bus.rx_eop   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"}, 64'(bus.frame_valid), 64'd0);
    chk({tag, " err"},   64'(bus.frame_err),   64'd0);
    chk({tag, " code"},  64'(bus.err_code),    64'd0);
    chk({tag, " cmd"},   64'(bus.frame_cmd),   64'd0);
    chk({tag, " len"},   64'(bus.frame_len),   64'd0);
    chk({tag, " count"}, 64'(bus.frame_count), 64'd0);
    chk({tag, " pay"},   bus.frame_payload,    64'd0);
    chk({tag, " busy"},  64'(bus.busy),        64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic seen;
    int   nvalid;

    n_checks = 0;
    n_err    = 0;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_eop   = 1'b0;
    rst_n = 1'b0;

    // ---- vector table -------------------------------------------------
    hc = 8'h00; hl = 4'd0; hn = 8'd0; hp = 64'h0;
    // good frame, checksum 10^02^11^22 = 21
    add(1, 8'hA5, 0, 0, 0, 0, 1);
    add(1, 8'h10, 0, 0, 0, 0, 1);
    add(1, 8'h02, 0, 0, 0, 0, 1);
    add(1, 8'h11, 0, 0, 0, 0, 1);
    add(1, 8'h22, 0, 0, 0, 0, 1);
    hc = 8'h10; hl = 4'd2; hn = 8'd1; hp = 64'h2211;
    add(1, 8'h21, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0);
    // different frame with bad checksum (good would be 20): outputs keep prior frame
    add(1, 8'hA5, 0, 0, 0, 0, 1);
    add(1, 8'h33, 0, 0, 0, 0, 1);
    add(1, 8'h02, 0, 0, 0, 0, 1);
    add(1, 8'h44, 0, 0, 0, 0, 1);
    add(1, 8'h55, 0, 0, 0, 0, 1);
    add(1, 8'h21, 0, 0, 1, 2, 0);
    add(0, 8'h00, 0, 0, 0, 2, 0);
    // length too large
    add(1, 8'hA5, 0, 0, 0, 2, 1);
    add(1, 8'h01, 0, 0, 0, 2, 1);
    add(1, 8'h09, 0, 0, 1, 1, 0);
    // zero-length frame, checksum 01
    add(1, 8'hA5, 0, 0, 0, 1, 1);
    add(1, 8'h01, 0, 0, 0, 1, 1);
    add(1, 8'h00, 0, 0, 0, 1, 1);
    hc = 8'h01; hl = 4'd0; hn = 8'd2; hp = 64'h0;
    add(1, 8'h01, 0, 1, 0, 1, 0);
    // noise and eop in idle are ignored
    add(1, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'hFF, 0, 0, 0, 1, 0);
    add(1, 8'h5A, 0, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'hA5, 0, 0, 0, 1, 1);
    add(1, 8'h10, 0, 0, 0, 1, 1);
    add(1, 8'h02, 0, 0, 0, 1, 1);
    add(1, 8'h11, 0, 0, 0, 1, 1);
    add(1, 8'h22, 0, 0, 0, 1, 1);
    hc = 8'h10; hl = 4'd2; hn = 8'd3; hp = 64'h2211;
    add(1, 8'h21, 0, 1, 0, 1, 0);
    // gap abort; byte with coincident eop is still consumed
    add(1, 8'hA5, 0, 0, 0, 1, 1);
    add(1, 8'h10, 0, 0, 0, 1, 1);
    add(1, 8'h02, 1, 0, 0, 1, 1);
    add(1, 8'h11, 0, 0, 0, 1, 1);
    add(0, 8'h00, 1, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 0, 3, 0);
    // full MAX_LEN frame, checksum 07^08^(01..08 xor = 08) = 07
    add(1, 8'hA5, 0, 0, 0, 3, 1);
    add(1, 8'h07, 0, 0, 0, 3, 1);
    add(1, 8'h08, 0, 0, 0, 3, 1);
    for (int i = 1; i <= 8; i++) add(1, 8'(i), 0, 0, 0, 3, 1);
    hc = 8'h07; hl = 4'd8; hn = 8'd4; hp = 64'h0807060504030201;
    add(1, 8'h07, 0, 1, 0, 3, 0);
    // length one past MAX_LEN
    add(1, 8'hA5, 0, 0, 0, 3, 1);
    add(1, 8'h07, 0, 0, 0, 3, 1);
    add(1, 8'h09, 0, 0, 1, 1, 0);

    // ---- reset state --------------------------------------------------
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rdy, vq[i].data, vq[i].eop);
      chk($sformatf("v%0d valid", i), 64'(bus.frame_valid), 64'(vq[i].ev));
      chk($sformatf("v%0d err", i),   64'(bus.frame_err),   64'(vq[i].ee));
      chk($sformatf("v%0d code", i),  64'(bus.err_code),    64'(vq[i].ec));
      chk($sformatf("v%0d busy", i),  64'(bus.busy),        64'(vq[i].eb));
      chk($sformatf("v%0d cmd", i),   64'(bus.frame_cmd),   64'(vq[i].ecmd));
      chk($sformatf("v%0d len", i),   64'(bus.frame_len),   64'(vq[i].elen));
      chk($sformatf("v%0d count", i), 64'(bus.frame_count), 64'(vq[i].ecnt));
      chk($sformatf("v%0d pay", i),   bus.frame_payload,    vq[i].epay);
    end

    // ---- asynchronous reset mid-frame ----------------------------------
    step(1, 8'hA5, 0);
    step(1, 8'h10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hA5, 0);
    step(1, 8'h10, 0);
    step(1, 8'h02, 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h21, 0);
    chk("post-reset valid", 64'(bus.frame_valid), 64'd1);
    chk("post-reset count", 64'(bus.frame_count), 64'd1);
    chk("post-reset pay",   bus.frame_payload,    64'h2211);

    // ---- stalled frame ------------------------------------------------
    step(1, 8'hA5, 0);
    step(1, 8'h10, 0);
    k = 0;
    seen = 1'b0;
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    while (!seen && k < 200) begin
      step(0, 8'h00, 0);
      k++;
      if (bus.frame_err) seen = 1'b1;
    end
    chk("timeout seen",   64'(seen),         64'd1);
    chk("timeout cycles", 64'(k),            64'(TMO));
    chk("timeout code",   64'(bus.err_code), 64'd3);
    chk("timeout busy",   64'(bus.busy),     64'd0);
`else
    for (int i = 0; i < 100; i++) begin
      step(0, 8'h00, 0);
      if (bus.frame_err) seen = 1'b1;
    end
    chk("stall no err", 64'(seen),     64'd0);
    chk("stall busy",   64'(bus.busy), 64'd1);
    step(0, 8'h00, 1);
    chk("stall eop err",  64'(bus.frame_err), 64'd1);
    chk("stall eop code", 64'(bus.err_code),  64'd3);
`endif

    // ---- counter wrap from reset ----------------------------------------
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int f = 0; f < 256; f++) begin
      step(1, 8'hA5, 0);
      step(1, 8'h10, 0);
      step(1, 8'h00, 0);
      step(1, 8'h10, 0);
      if (bus.frame_valid) nvalid++;
      if (f == 254) chk("count at 255", 64'(bus.frame_count), 64'd255);
    end
    chk("wrap valid pulses", 64'(nvalid),          64'd256);
    chk("wrap count",        64'(bus.frame_count), 64'd0);
    chk("wrap len",          64'(bus.frame_len),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
